// File: rtl/clk_period_meter.sv
// Measures the half-period of a toggling wave in clk_50 cycles, with lock and stall flags.
// Define CLK_METER_AVG_EN to report the truncated mean of every four measurements instead.
module clk_period_meter #(
  parameter int W       = 32,
  parameter int TIMEOUT = 50_000_000,
  parameter int TOL     = 0
) (
  input  logic         clk_50,
  input  logic         reset_n,
  input  logic         sig_in,
  output logic [W-1:0] half_period,
  output logic         meas_valid,
  output logic         locked,
  output logic         stalled
);

  typedef enum logic {IDLE, MEASURE} state_t;

  localparam logic [W-1:0] TIMEOUT_W = W'(TIMEOUT);
  localparam logic [W-1:0] TOL_W     = W'(TOL);

  logic         r_s1, r_s2, r_s3;
  logic [W-1:0] r_cnt;
  logic [W-1:0] r_prev;
  state_t       r_state;

  logic         w_edge;
  logic         w_timeout;
  logic         w_emit;
  logic         w_lock;
  logic [W-1:0] w_meas;
  logic [W-1:0] w_diff;

  assign w_edge    = r_s2 ^ r_s3;
  assign w_timeout = !w_edge && (r_cnt == TIMEOUT_W);

`ifdef CLK_METER_AVG_EN
  logic [W+1:0] r_sum;
  logic [W+1:0] w_sum_next;
  logic [1:0]   r_nmeas;

  // The fourth sample is folded in combinationally so the mean is ready on that edge.
  assign w_sum_next = r_sum + {2'b00, r_cnt};
  assign w_emit     = (r_nmeas == 2'd3);
  assign w_meas     = w_sum_next[W+1:2];
`else
  assign w_emit = 1'b1;
  assign w_meas = r_cnt;
`endif

  // Unsigned distance as larger minus smaller, so it never wraps.
  assign w_diff = (w_meas >= r_prev) ? (w_meas - r_prev) : (r_prev - w_meas);
  assign w_lock = (r_prev != '0) && (w_diff <= TOL_W);

  // NOTE: asynchronous reset clears all state immediately; every sequential update below is
  // non-blocking, so later assignments in the block override the defaults made earlier.
  always_ff @(posedge clk_50 or negedge reset_n) begin
    if (!reset_n) begin
      r_s1        <= 1'b0;
      r_s2        <= 1'b0;
      r_s3        <= 1'b0;
      r_cnt       <= '0;
      r_prev      <= '0;
      r_state     <= IDLE;
      half_period <= '0;
      meas_valid  <= 1'b0;
      locked      <= 1'b0;
      stalled     <= 1'b0;
`ifdef CLK_METER_AVG_EN
      r_sum       <= '0;
      r_nmeas     <= '0;
`endif
    end else begin
      r_s1       <= sig_in;
      r_s2       <= r_s1;
      r_s3       <= r_s2;
      meas_valid <= 1'b0;

      if (r_cnt != TIMEOUT_W) begin
        r_cnt <= r_cnt + W'(1);
      end

      if (r_state == IDLE) begin
        if (w_edge) begin
          r_cnt   <= W'(1);
          stalled <= 1'b0;
          r_state <= MEASURE;
        end
      end else if (w_edge) begin
        r_cnt <= W'(1);
        if (w_emit) begin
          half_period <= w_meas;
          r_prev      <= w_meas;
          meas_valid  <= 1'b1;
          locked      <= w_lock;
        end
`ifdef CLK_METER_AVG_EN
        r_nmeas <= r_nmeas + 2'd1;
        r_sum   <= w_emit ? '0 : w_sum_next;
`endif
      end

      // An edge in the same cycle suppresses the timeout.
      if (w_timeout) begin
        stalled     <= 1'b1;
        half_period <= '0;
        locked      <= 1'b0;
        r_prev      <= '0;
        r_state     <= IDLE;
`ifdef CLK_METER_AVG_EN
        r_sum       <= '0;
        r_nmeas     <= '0;
`endif
      end
    end
  end

endmodule

// File: tb/tb_clk_period_meter.sv
// Bench for clk_period_meter: a gap-level model feeds a scoreboard queue that a monitor drains
// on each meas_valid, plus timed checks of reset, stall entry and stall release.
module tb_clk_period_meter;

  localparam int W       = 32;
  localparam int TIMEOUT = 100;
  localparam int TOL     = 1;

  typedef struct {
    longint hp;
    logic   lk;
  } exp_t;

  logic         clk_50  = 1'b0;
  logic         reset_n = 1'b1;
  logic         sig_in  = 1'b0;
  logic [W-1:0] half_period;
  logic         meas_valid;
  logic         locked;
  logic         stalled;

  int     n_checks    = 0;
  int     n_pass      = 0;
  int     cyc         = 0;
  int     last_tog    = 0;
  int     last_mv_cyc = -1;
  exp_t   exp_q[$];

  bit     m_has_ref = 1'b0;
  longint m_prev    = 0;
  longint m_sum     = 0;
  int     m_n       = 0;

  int seq_a[] = '{5, 5, 5, 5, 5, 5, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 5, 5, 5, 8, 8};
  int seq_b[] = '{6, 5, 5, 7, 7, 100, 101, 3, 3, 4, 6, 4, 6, 4, 6, 4, 6};

  clk_period_meter #(
    .W       (W),
    .TIMEOUT (TIMEOUT),
    .TOL     (TOL)
  ) dut (
    .clk_50      (clk_50),
    .reset_n     (reset_n),
    .sig_in      (sig_in),
    .half_period (half_period),
    .meas_valid  (meas_valid),
    .locked      (locked),
    .stalled     (stalled)
  );

  always #10 clk_50 = ~clk_50;

  always @(posedge clk_50) cyc++;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  // Reference model: works purely on the gaps between input toggles.
  task automatic model_edge(input longint gap);
    longint meas;
    exp_t   e;
    if (!m_has_ref || gap > TIMEOUT) begin
      m_has_ref = 1'b1;
      m_prev    = 0;
      m_sum     = 0;
      m_n       = 0;
      return;
    end
`ifdef CLK_METER_AVG_EN
    m_sum += gap;
    m_n++;
    if (m_n < 4) return;
    meas  = m_sum / 4;
    m_sum = 0;
    m_n   = 0;
`else
    meas = gap;
`endif
    e.hp = meas;
    e.lk = (m_prev != 0) && (((meas > m_prev) ? meas - m_prev : m_prev - meas) <= TOL);
    exp_q.push_back(e);
    m_prev = meas;
  endtask

  task automatic model_reset();
    m_has_ref = 1'b0;
    m_prev    = 0;
    m_sum     = 0;
    m_n       = 0;
    exp_q.delete();
  endtask

  // Toggle sig_in once at least 'gap' clocks have passed since the previous toggle.
  task automatic toggle_gap(input int gap);
    do begin
      @(posedge clk_50);
      #1;
    end while (cyc < last_tog + gap);
    sig_in = ~sig_in;
    model_edge(longint'(cyc - last_tog));
    last_tog = cyc;
  endtask

  task automatic check_zero(input string tag);
    check({tag, " half_period"}, half_period, 0);
    check({tag, " meas_valid"}, meas_valid, 0);
    check({tag, " locked"}, locked, 0);
    check({tag, " stalled"}, stalled, 0);
  endtask

  task automatic drain_and_reset(input string tag);
    repeat (6) @(negedge clk_50);
    check({tag, " expectations consumed"}, exp_q.size(), 0);
    check({tag, " half_period nonzero"}, half_period != '0, 1);
    #3 reset_n = 1'b0;
    sig_in = 1'b0;
    model_reset();
    #1 check_zero({tag, " async"});
    @(negedge clk_50);
    check_zero({tag, " held"});
    reset_n = 1'b1;
  endtask

  always @(negedge clk_50) begin : monitor
    exp_t e;
    if (reset_n && meas_valid) begin
      last_mv_cyc = cyc;
      if (exp_q.size() == 0) begin
        check("unexpected meas_valid", 1, 0);
      end else begin
        e = exp_q.pop_front();
        check("half_period", half_period, e.hp);
        check("locked", locked, e.lk);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int m;
    int prev_g;
    #2 reset_n = 1'b0;

    for (int i = 0; i < 4; i++) begin
      @(posedge clk_50);
      #1 sig_in = ~sig_in;
      @(negedge clk_50);
      check_zero("in reset");
    end
    sig_in = 1'b0;
    @(negedge clk_50);
    reset_n = 1'b1;

    // Steady 5, continuous toggling, then a period change.
    toggle_gap(1);
    foreach (seq_a[i]) toggle_gap(seq_a[i]);
    drain_and_reset("mid-count reset");

    // Tolerance boundary, edge coinciding with timeout, one past timeout, averaging pattern.
    toggle_gap(1);
    foreach (seq_b[i]) toggle_gap(seq_b[i]);
    drain_and_reset("pre-stall reset");

    // Stall: outputs drop exactly TIMEOUT cycles after the last measured edge.
    toggle_gap(1);
    repeat (4) toggle_gap(5);
    for (int k = 0; k < 10 && exp_q.size() != 0; k++) @(negedge clk_50);
    check("last measurement before stall", exp_q.size(), 0);
    m = last_mv_cyc;
    while (cyc < m + TIMEOUT - 1) @(negedge clk_50);
    check("stalled one cycle early", stalled, 0);
    @(negedge clk_50);
    check("stalled at timeout", stalled, 1);
    check("half_period at timeout", half_period, 0);
    check("locked at timeout", locked, 0);

    // Resume: first edge clears stalled without a measurement.
    toggle_gap(1);
    @(negedge clk_50);
    check("stalled held until edge seen", stalled, 1);
    repeat (3) @(negedge clk_50);
    check("stalled cleared by first edge", stalled, 0);
    repeat (4) toggle_gap(7);

    // Randomised gaps, biased toward near-repeats and the timeout boundary.
    prev_g = 5;
    for (int i = 0; i < 150; i++) begin
      int r;
      int g;
      r = int'($urandom_range(0, 19));
      if (r == 0) g = int'($urandom_range(TIMEOUT - 2, TIMEOUT + 3));
      else if (r < 9) g = (prev_g > 1) ? prev_g - 1 + int'($urandom_range(0, 2)) : 1 + int'($urandom_range(0, 1));
      else g = int'($urandom_range(1, 12));
      toggle_gap(g);
      prev_g = g;
    end

    repeat (8) @(negedge clk_50);
    check("all expected measurements seen", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
